// File: rtl/psum_accum_requant_pkg.sv
// Shared defaults and fixed-point helpers for the partial-sum accumulate / requantise path.
// Helpers work on a wide signed type so any module width can reuse them.
package psum_accum_requant_pkg;

    localparam int DEF_IN_W       = 16;
    localparam int DEF_ACC_W      = 24;
    localparam int DEF_OUT_W      = 8;
    localparam int ACC_LEN_3X3    = 9;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef logic signed [63:0] wide_t;

    // Clamp a wide signed value into the range of a w-bit two's complement number.
    function automatic wide_t sat_signed(input wide_t v, input int unsigned w);
        wide_t maxv;
        wide_t minv;
        maxv = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        minv = -(wide_t'(1) <<< (w - 1));
        if (v > maxv) begin
            return maxv;
        end else if (v < minv) begin
            return minv;
        end
        return v;
    endfunction

    // Round-half-up arithmetic right shift; a shift of zero passes the value through.
    function automatic wide_t round_shift(input wide_t v, input logic [4:0] sh);
        wide_t half;
        half = (sh == 5'd0) ? wide_t'(0) : (wide_t'(1) <<< (sh - 5'd1));
        return (v + half) >>> sh;
    endfunction

endpackage

// File: rtl/psum_result_fifo.sv
// Small synchronous result FIFO with a registered occupancy count.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module psum_result_fifo
    import psum_accum_requant_pkg::*;
#(
    parameter int WIDTH = DEF_OUT_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;

    // Head is forced to zero when empty so stale entries never leak onto the bus.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/psum_accum_requant.sv
// Accumulates ACC_LEN PE products per output pixel, rounds/shifts/saturates to OUT_W and queues results.
// Optional feature macro: PSUM_ACC_RELU_EN clamps negative requantised results to zero.
module psum_accum_requant
    import psum_accum_requant_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int ACC_LEN    = ACC_LEN_3X3,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic signed [IN_W-1:0]  psum_in,
    input  logic                    psum_valid,
    input  logic signed [IN_W-1:0]  bias,
    input  logic [4:0]              shift_amt,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    overflow_flag,
    output logic                    acc_sat_flag
);

    localparam int               CNT_W    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);
    localparam logic [4:0]       MAX_SH   = 5'(ACC_W - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]              sh_q, sh_d;
    logic                    done_q, done_d;
    logic signed [ACC_W-1:0] s1_q;
    logic [4:0]              s1_sh_q;
    logic                    s1_valid_q;
    logic signed [ACC_W:0]   s2_q, s2_d;
    logic                    s2_valid_q;
    logic                    acc_sat_q;
    logic                    overflow_q;

    wide_t                   base_w;
    wide_t                   sum_w;
    wide_t                   r_w;
    wide_t                   relu_w;
    logic                    sat_hit;
    logic [4:0]              sh_clamped;
    logic [OUT_W-1:0]        push_data;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_drop;
    logic                    fifo_pop;
    logic [OUT_W-1:0]        fifo_head;

    assign sh_clamped = (shift_amt > MAX_SH) ? MAX_SH : shift_amt;

    // Window accumulation: the first product of a window starts from bias instead of the running sum.
    always_comb begin
        base_w  = (cnt_q == '0) ? wide_t'(bias) : wide_t'(acc_q);
        sum_w   = base_w + wide_t'(psum_in);
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        sat_hit = 1'b0;
        if (psum_valid) begin
            acc_d   = ACC_W'(sat_signed(sum_w, ACC_W));
            sat_hit = (sat_signed(sum_w, ACC_W) != sum_w);
            if (cnt_q == '0) begin
                sh_d = sh_clamped;
            end
            if (cnt_q == LAST_CNT) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign s2_d = (ACC_W + 1)'(round_shift(wide_t'(s1_q), s1_sh_q));

    always_comb begin
        r_w = wide_t'(s2_q);
`ifdef PSUM_ACC_RELU_EN
        relu_w = (r_w < 0) ? wide_t'(0) : r_w;
`else
        relu_w = r_w;
`endif
        push_data = OUT_W'(sat_signed(relu_w, OUT_W));
    end

    // done_q marks the cycle after a window closes, so S1 copies the finished sum while acc restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            sh_q       <= '0;
            done_q     <= 1'b0;
            s1_q       <= '0;
            s1_sh_q    <= '0;
            s1_valid_q <= 1'b0;
            s2_q       <= '0;
            s2_valid_q <= 1'b0;
            acc_sat_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            sh_q       <= '0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            acc_sat_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            done_q     <= done_d;
            s1_valid_q <= done_q;
            if (done_q) begin
                s1_q    <= acc_q;
                s1_sh_q <= sh_q;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_q <= s2_d;
            end
            acc_sat_q  <= acc_sat_q | sat_hit;
            overflow_q <= overflow_q | fifo_drop;
        end
    end

    assign fifo_pop = !fifo_empty && out_ready;

    psum_result_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .push_i      (s2_valid_q),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .rd_data_o   (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .drop_o      (fifo_drop)
    );

    assign out_data      = fifo_head;
    assign out_valid     = !fifo_empty;
    assign busy          = (cnt_q != '0) || done_q || s1_valid_q || s2_valid_q || !fifo_empty;
    assign overflow_flag = overflow_q;
    assign acc_sat_flag  = acc_sat_q;

endmodule

// File: tb/tb_psum_accum_requant.sv
// Directed bench for psum_accum_requant: scoreboard of expected results checked on every FIFO pop.
// A second instance with a 512-product window exercises accumulator saturation.
module tb_psum_accum_requant;

    localparam longint ACC_MAX = 64'sd8388607;
    localparam longint ACC_MIN = -64'sd8388608;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clear;
    logic signed [15:0] psum_in;
    logic               psum_valid;
    logic signed [15:0] bias;
    logic [4:0]         shift_amt;
    logic signed [7:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               overflow_flag;
    logic               acc_sat_flag;

    logic signed [15:0] l_psum_in;
    logic               l_psum_valid;
    logic signed [15:0] l_bias;
    logic [4:0]         l_shift_amt;
    logic signed [7:0]  l_out_data;
    logic               l_out_valid;
    logic               l_busy;
    logic               l_overflow_flag;
    logic               l_acc_sat_flag;
    logic               l_clear;
    logic               l_out_ready;

    int                 checks = 0;
    int                 errors = 0;
    int                 popCount = 0;
    int                 sbQueue[$];
    logic signed [31:0] monObs;
    logic signed [31:0] monExp;

    always #5 clk = ~clk;

    psum_accum_requant u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .psum_in       (psum_in),
        .psum_valid    (psum_valid),
        .bias          (bias),
        .shift_amt     (shift_amt),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .overflow_flag (overflow_flag),
        .acc_sat_flag  (acc_sat_flag)
    );

    psum_accum_requant #(.ACC_LEN(512)) u_dut_long (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (l_clear),
        .psum_in       (l_psum_in),
        .psum_valid    (l_psum_valid),
        .bias          (l_bias),
        .shift_amt     (l_shift_amt),
        .out_data      (l_out_data),
        .out_valid     (l_out_valid),
        .out_ready     (l_out_ready),
        .busy          (l_busy),
        .overflow_flag (l_overflow_flag),
        .acc_sat_flag  (l_acc_sat_flag)
    );

    // Reference model: saturating window sum, round-half-up shift, optional ReLU, int8 clamp.
    function automatic int modelWindow(input longint b, input longint v, input int n, input int sh,
                                       output bit sat);
        longint acc;
        longint r;
        int     shc;
        sat = 1'b0;
        acc = b;
        for (int i = 0; i < n; i++) begin
            acc = acc + v;
            if (acc > ACC_MAX) begin
                acc = ACC_MAX;
                sat = 1'b1;
            end else if (acc < ACC_MIN) begin
                acc = ACC_MIN;
                sat = 1'b1;
            end
        end
        shc = (sh > 23) ? 23 : sh;
        r = (shc == 0) ? acc : ((acc + (64'sd1 <<< (shc - 1))) >>> shc);
`ifdef PSUM_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic pushExpected(input longint b, input longint v, input int n, input int sh);
        bit s;
        sbQueue.push_back(modelWindow(b, v, n, sh, s));
    endtask

    task automatic stepCycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic signed [15:0] b, input logic [4:0] sh,
                                 input logic signed [15:0] v, input int n, input int maxGap);
        bias      = b;
        shift_amt = sh;
        for (int i = 0; i < n; i++) begin
            psum_in    = v;
            psum_valid = 1'b1;
            stepCycle(1);
            psum_valid = 1'b0;
            if (maxGap > 0 && i != n - 1) begin
                stepCycle(int'($urandom_range(maxGap, 0)));
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, $signed(observed), $signed(expected));
        end
    endtask

    // Scoreboard: every accepted FIFO word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            popCount++;
            checks++;
            assert (sbQueue.size() != 0)
            else begin
                errors++;
                $error("[TB] FAIL sb_underflow: observed %0d, expected no output", out_data);
            end
            if (sbQueue.size() != 0) begin
                monExp = sbQueue.pop_front();
                monObs = out_data;
                assert (monObs === monExp)
                else begin
                    errors++;
                    $error("[TB] FAIL sb_data: observed %0d, expected %0d", monObs, monExp);
                end
            end
        end
    end

    initial begin
        int  pc;
        int  expLong;
        bit  expLongSat;

        rst_n        = 1'b0;
        clear        = 1'b0;
        psum_in      = '0;
        psum_valid   = 1'b0;
        bias         = '0;
        shift_amt    = '0;
        out_ready    = 1'b1;
        l_psum_in    = '0;
        l_psum_valid = 1'b0;
        l_bias       = '0;
        l_shift_amt  = '0;
        l_clear      = 1'b0;
        l_out_ready  = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_overflow", 32'(overflow_flag), 0);
        checkOutput("rst_acc_sat", 32'(acc_sat_flag), 0);
        stepCycle(2);
        rst_n = 1'b1;
        stepCycle(1);

        $display("[TB] test 1: basic window and latency");
        pushExpected(4, 10, 9, 2);
        applyStimulus(16'sd4, 5'd2, 16'sd10, 9, 0);
        stepCycle(2);
        checkOutput("t1_valid_E2", 32'(out_valid), 0);
        stepCycle(1);
        checkOutput("t1_valid_E3", 32'(out_valid), 1);
        checkOutput("t1_data", 32'(out_data), 24);
        stepCycle(3);

        $display("[TB] test 2: negative saturation");
        pushExpected(0, -1000, 9, 4);
        applyStimulus(16'sd0, 5'd4, -16'sd1000, 9, 0);
        stepCycle(5);
        checkOutput("t2_acc_sat", 32'(acc_sat_flag), 0);

        $display("[TB] test 3: gapped valids");
        pushExpected(0, 1, 9, 0);
        applyStimulus(16'sd0, 5'd0, 16'sd1, 9, 3);
        stepCycle(6);
        checkOutput("t3_busy", 32'(busy), 0);

        $display("[TB] test 4: FIFO fill and overflow");
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) pushExpected(0, 1, 9, 0);
            applyStimulus(16'sd0, 5'd0, 16'sd1, 9, 0);
        end
        stepCycle(5);
        checkOutput("t4_valid", 32'(out_valid), 1);
        checkOutput("t4_head", 32'(out_data), 9);
        checkOutput("t4_overflow", 32'(overflow_flag), 1);
        stepCycle(2);
        checkOutput("t4_head_stable", 32'(out_data), 9);
        pc = popCount;
        out_ready = 1'b1;
        stepCycle(8);
        checkOutput("t4_pop_count", 32'(popCount - pc), 4);
        checkOutput("t4_drained", 32'(out_valid), 0);

        $display("[TB] test 5: clear mid-window");
        applyStimulus(16'sd0, 5'd0, 16'sd100, 4, 0);
        clear      = 1'b1;
        psum_valid = 1'b1;
        psum_in    = 16'sd100;
        stepCycle(1);
        clear      = 1'b0;
        psum_valid = 1'b0;
        checkOutput("t5_clr_valid", 32'(out_valid), 0);
        checkOutput("t5_clr_busy", 32'(busy), 0);
        checkOutput("t5_clr_overflow", 32'(overflow_flag), 0);
        pushExpected(1, 2, 9, 0);
        applyStimulus(16'sd1, 5'd0, 16'sd2, 9, 0);
        stepCycle(5);
        checkOutput("t5_overflow", 32'(overflow_flag), 0);
        checkOutput("t5_acc_sat", 32'(acc_sat_flag), 0);

        $display("[TB] test 6: long window accumulator saturation");
        expLong = modelWindow(0, 32767, 512, 16, expLongSat);
        l_bias      = 16'sd0;
        l_shift_amt = 5'd16;
        for (int i = 0; i < 512; i++) begin
            l_psum_in    = 16'sd32767;
            l_psum_valid = 1'b1;
            stepCycle(1);
        end
        l_psum_valid = 1'b0;
        stepCycle(3);
        checkOutput("t6_valid", 32'(l_out_valid), 1);
        checkOutput("t6_data", 32'(l_out_data), 32'(expLong));
        checkOutput("t6_acc_sat", 32'(l_acc_sat_flag), 32'(expLongSat));
        stepCycle(2);

        $display("[TB] test 7: reset mid-window");
        applyStimulus(16'sd0, 5'd0, 16'sd5, 4, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("t7_valid", 32'(out_valid), 0);
        checkOutput("t7_data", 32'(out_data), 0);
        checkOutput("t7_busy", 32'(busy), 0);
        checkOutput("t7_overflow", 32'(overflow_flag), 0);
        checkOutput("t7_acc_sat", 32'(acc_sat_flag), 0);
        stepCycle(1);
        rst_n = 1'b1;
        stepCycle(1);
        pushExpected(0, 1, 9, 0);
        applyStimulus(16'sd0, 5'd0, 16'sd1, 9, 0);
        stepCycle(6);
        checkOutput("t7_busy_after", 32'(busy), 0);
        checkOutput("sb_empty", 32'(sbQueue.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
